cs_resolve_pipe: RTL and testbench

- Consumer end of the carry-save multiplier interface: accepts a redundant (sum, carry) pair, such as mult_cs #(16) output at W=32, and resolves it to a binary result equal to (sum + carry) mod 2^W.
- Carry-propagate add is split into CHUNK-bit slices, one slice per pipeline stage, so the final adder runs off the multiplier's combinational path.
- Valid/ready handshake on both sides; sits between the Wallace-tree multiplier and downstream datapath.

---
 rtl/cs_resolve_pkg.sv | 23 ++
 rtl/cs_resolve_stage.sv | 72 +++++++
 rtl/cs_resolve_pipe.sv | 121 ++++++++++++
 tb/tb_cs_resolve_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_resolve_pkg.sv
// cs_resolve_pkg: shared definitions for the carry-save resolve pipeline.
//   CS_W_DEF / CS_CHUNK_DEF : default operand width and bits resolved per stage
//   ERRCNT_W                : width of the self-check mismatch counter
//   stage_ctl_t             : per-stage valid/carry bundle
//   stages_f                : number of pipeline stages for a given W and CHUNK
package cs_resolve_pkg;

  localparam int CS_W_DEF     = 32;
  localparam int CS_CHUNK_DEF = 8;
  localparam int ERRCNT_W     = 16;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  // Guarded against CHUNK=0 so the static check in the top can still elaborate
  // and report the real problem.
  function automatic int stages_f(input int w, input int chunk);
    return (chunk > 0) ? (w / chunk) : 1;
  endfunction

endpackage

// File: rtl/cs_resolve_stage.sv
// cs_resolve_stage: one pipeline stage of the carry-save resolver.
// Adds slice IDX of the sum and carry vectors plus the incoming carry, and
// registers the resolved slice together with everything later stages need.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                global advance enable (all stages shift together)
//   valid_i / valid_o stage valid bit in / registered out
//   carry_i / carry_o carry into this slice / registered carry out of it
//   sum_i,  sum_o     carry-save sum vector (upper slices still unresolved)
//   car_i,  car_o     carry-save carry vector
//   res_i,  res_o     result vector; slices below IDX already resolved
module cs_resolve_stage
  import cs_resolve_pkg::*;
#(
  parameter int W     = CS_W_DEF,
  parameter int CHUNK = CS_CHUNK_DEF,
  parameter int IDX   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         valid_i,
  input  logic         carry_i,
  input  logic [W-1:0] sum_i,
  input  logic [W-1:0] car_i,
  input  logic [W-1:0] res_i,
  output logic         valid_o,
  output logic         carry_o,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] car_o,
  output logic [W-1:0] res_o
);

  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0] w_add;
  logic [W-1:0]   w_res_next;

  stage_ctl_t     r_ctl;
  logic [W-1:0]   r_sum;
  logic [W-1:0]   r_car;
  logic [W-1:0]   r_res;

  always_comb begin
    w_add      = {1'b0, sum_i[LO +: CHUNK]} + {1'b0, car_i[LO +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_i};
    w_res_next = res_i;
    w_res_next[LO +: CHUNK] = w_add[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl <= '0;
      r_sum <= '0;
      r_car <= '0;
      r_res <= '0;
    end else if (en) begin
      r_ctl.valid <= valid_i;
      r_ctl.carry <= w_add[CHUNK];
      r_sum       <= sum_i;
      r_car       <= car_i;
      r_res       <= w_res_next;
    end
  end

  assign valid_o = r_ctl.valid;
  assign carry_o = r_ctl.carry;
  assign sum_o   = r_sum;
  assign car_o   = r_car;
  assign res_o   = r_res;

endmodule

// File: rtl/cs_resolve_pipe.sv
// cs_resolve_pipe: resolves a carry-save (sum, carry) pair into a binary
// result (in_sum + in_carry) mod 2^W, one CHUNK-bit slice per pipeline stage.
// Optional feature macro: CS_RESOLVE_SELFCHECK_EN (shadow reference pipeline
// and saturating mismatch counter on err_cnt; err_cnt is 0 without it).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake
//   in_sum, in_carry        carry-save pair (carry already weight-aligned)
//   out_valid/out_ready     output handshake
//   out_result, out_cout    resolved sum and raw carry out of bit W-1
//   err_cnt                 self-check mismatch count
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// whole pipe advances together when en = !out_valid || out_ready; in_ready
// equals en and never looks at in_valid. Bubbles travel with the data, and
// the output holds steady while out_valid && !out_ready.
module cs_resolve_pipe
  import cs_resolve_pkg::*;
#(
  parameter int W     = CS_W_DEF,
  parameter int CHUNK = CS_CHUNK_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_sum,
  input  logic [W-1:0]        in_carry,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_result,
  output logic                out_cout,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int STAGES = stages_f(W, CHUNK);

  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("cs_resolve_pipe: CHUNK must be at least 1");
    end else if ((W % CHUNK) != 0) begin : g_bad_width
      $error("cs_resolve_pipe: W must be a multiple of CHUNK");
    end
  endgenerate

  logic         w_en;
  logic         w_valid [0:STAGES];
  logic         w_carry [0:STAGES];
  logic [W-1:0] w_sum   [0:STAGES];
  logic [W-1:0] w_car   [0:STAGES];
  logic [W-1:0] w_res   [0:STAGES];

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Stage 0 only ever loads on en, so in_valid alone is the entering valid bit.
  assign w_valid[0] = in_valid;
  assign w_carry[0] = 1'b0;
  assign w_sum[0]   = in_sum;
  assign w_car[0]   = in_carry;
  assign w_res[0]   = '0;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cs_resolve_stage #(
        .W     (W),
        .CHUNK (CHUNK),
        .IDX   (k)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_en),
        .valid_i (w_valid[k]),
        .carry_i (w_carry[k]),
        .sum_i   (w_sum[k]),
        .car_i   (w_car[k]),
        .res_i   (w_res[k]),
        .valid_o (w_valid[k+1]),
        .carry_o (w_carry[k+1]),
        .sum_o   (w_sum[k+1]),
        .car_o   (w_car[k+1]),
        .res_o   (w_res[k+1])
      );
    end
  endgenerate

  assign out_valid  = w_valid[STAGES];
  assign out_result = w_res[STAGES];
  assign out_cout   = w_carry[STAGES];

  // The last stage's copies of the input vectors have no consumer.
  logic w_unused;
  assign w_unused = ^{w_sum[STAGES], w_car[STAGES]};

`ifdef CS_RESOLVE_SELFCHECK_EN
  logic [W-1:0]        r_ref [0:STAGES-1];
  logic [ERRCNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) r_ref[k] <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_en) begin
        r_ref[0] <= in_sum + in_carry;
        for (int k = 1; k < STAGES; k++) r_ref[k] <= r_ref[k-1];
      end
      if (out_valid && out_ready && (r_ref[STAGES-1] != out_result)) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        $error("cs_resolve_pipe: result %h differs from reference %h",
               out_result, r_ref[STAGES-1]);
      end
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cs_resolve_pipe.sv
// tb_cs_resolve_pipe: scoreboard bench for cs_resolve_pipe at W=32, CHUNK=8.
// Drivers push the expected {cout, result} at acceptance; a negedge monitor
// pops and compares on every output handshake, and also checks latency in
// advancing clock edges and output stability while stalled.
module tb_cs_resolve_pipe;

  localparam int W   = 32;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_sum = '0;
  logic [W-1:0] in_carry = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_cout;
  logic [15:0]  err_cnt;

  cs_resolve_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .err_cnt    (err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_out   = 0;
  int           adv_cnt = 0;
  logic [W:0]   exp_q[$];
  int           tag_q[$];
  logic [W:0]   pend_exp = '0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_res = '0;
  logic         stall_cout = 1'b0;
  logic         done_gen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the resolved value is simply the 33-bit sum of the pair.
  function automatic logic [W:0] model_add(input logic [W-1:0] s, input logic [W-1:0] c);
    return {1'b0, s} + {1'b0, c};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      logic [W:0] e;
      int         tag;
      if (stall_prev) begin
        check("stall_hold_valid", out_valid, 1'b1);
        check("stall_hold_result", out_result, stall_res);
        check("stall_hold_cout", out_cout, stall_cout);
      end
      stall_prev = out_valid && !out_ready;
      stall_res  = out_result;
      stall_cout = out_cout;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got result %0h with no pending item", out_result);
        end else begin
          e   = exp_q.pop_front();
          tag = tag_q.pop_front();
          check("result", out_result, e[W-1:0]);
          check("cout", out_cout, e[W]);
          check("latency_edges", adv_cnt - tag, LAT);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(pend_exp);
        tag_q.push_back(adv_cnt);
      end
      if (in_ready) adv_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W:0] e);
    in_sum   = s;
    in_carry = c;
    pend_exp = e;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic send_rand();
    logic [W-1:0] s, c;
    s = $urandom;
    c = $urandom;
    send(s, c, model_add(s, c));
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 500; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_queue_empty", exp_q.size(), 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ai, bi;
    logic [W-1:0] prod, s, c;
    logic [W:0]   raw;

    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, '0);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_err_cnt", err_cnt, '0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Directed single pair and full carry ripple across all slices.
    send(32'h0000_1234, 32'h0000_0F0F, {1'b0, 32'h0000_2143});
    drain();
    send(32'hFFFF_FFFF, 32'h0000_0001, {1'b1, 32'h0000_0000});
    drain();
    send(32'h8000_0000, 32'h8000_0000, {1'b1, 32'h0000_0000});
    drain();

    // Back-to-back stream of signed 16x16 products in carry-save form.
    for (int i = 0; i < 64; i++) begin
      ai   = int'($urandom_range(0, 65535)) - 32768;
      bi   = int'($urandom_range(0, 65535)) - 32768;
      prod = ai * bi;
      s    = $urandom;
      c    = prod - s;
      raw  = {1'b0, s} + {1'b0, c};
      send(s, c, {raw[W], prod});
    end
    drain();

    // Backpressure: fill the pipe, stall 5 cycles with a pair waiting.
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) send_rand();
    s        = $urandom;
    c        = $urandom;
    in_sum   = s;
    in_carry = c;
    pend_exp = model_add(s, c);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Bubbles: alternate valid and idle cycles.
    for (int i = 0; i < 8; i++) begin
      send_rand();
      tick();
    end
    drain();

    // Random gaps with random downstream backpressure.
    done_gen = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send_rand();
        end
        done_gen = 1'b1;
      end
      begin
        while (!done_gen) begin
          tick();
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three pairs in flight, the oldest already on the output.
    send_rand();
    send_rand();
    send_rand();
    tick();
    check("pre_reset_out_valid", out_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_result", out_result, '0);
    check("mid_rst_out_cout", out_cout, 1'b0);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send(32'h0000_00FF, 32'h0000_0001, {1'b0, 32'h0000_0100});
    drain();
    send_rand();
    drain();

    check("final_err_cnt", err_cnt, '0);
    check("total_outputs", n_out, 3 + 64 + 5 + 8 + 40 + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
